// File: rtl/parity_frame_gen_if.sv
// Valid/ready stream bundle for the parity frame generator: input words in,
// tagged data/parity words out.
`timescale 1ns/1ps
interface parity_frame_gen_if #(
  parameter int WIDTH = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_wpar;
  logic             out_is_parity;
  logic             out_trunc;

  // Generator side: consumes the input stream, produces the output stream.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_wpar, out_is_parity, out_trunc
  );

  // Source/sink side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_wpar, out_is_parity, out_trunc
  );
endinterface

// File: rtl/parity_frame_gen.sv
// Streaming parity generator: forwards words with a per-word parity bit and
// appends one column-parity word after each frame (odd/even chosen per frame).
`timescale 1ns/1ps
module parity_frame_gen #(
  parameter int WIDTH   = 3,
  parameter int MAX_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 odd_sel,
  parity_frame_gen_if.slave    bus
);
  localparam int CW = $clog2(MAX_LEN + 1);

  typedef enum logic {
    PASS   = 1'b0,
    INSERT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             mode_q;
  logic             mode_d;
  logic             trunc_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_wpar_q;
  logic             out_is_par_q;
  logic             out_trunc_q;

  logic             out_free;
  logic             in_ready;
  logic             in_fire;
  logic             first_word;
  logic             at_max;
  logic [WIDTH-1:0] par_word;

  // Handshake decode and next accumulator/mode for an accepted data word.
  always_comb begin
    out_free   = !out_valid_q || bus.out_ready;
    in_ready   = (state_q == PASS) && out_free;
    in_fire    = in_ready && bus.in_valid;
    first_word = (cnt_q == '0);
    mode_d     = first_word ? odd_sel : mode_q;
    acc_d      = (first_word ? '0 : acc_q) ^ bus.in_data;
    at_max     = (cnt_q == CW'(MAX_LEN - 1));
    par_word   = acc_q ^ {WIDTH{mode_q}};
  end

  // Frame FSM with registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PASS;
      acc_q        <= '0;
      cnt_q        <= '0;
      mode_q       <= 1'b1;
      trunc_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_wpar_q   <= 1'b0;
      out_is_par_q <= 1'b0;
      out_trunc_q  <= 1'b0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        PASS: begin
          if (in_fire) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= bus.in_data;
            out_wpar_q   <= (^bus.in_data) ^ mode_d;
            out_is_par_q <= 1'b0;
            out_trunc_q  <= 1'b0;
            acc_q        <= acc_d;
            cnt_q        <= cnt_q + CW'(1);
            mode_q       <= mode_d;
            if (bus.in_last) begin
              state_q <= INSERT;
              trunc_q <= 1'b0;
            end else if (at_max) begin
              state_q <= INSERT;
              trunc_q <= 1'b1;
            end
          end
        end
        INSERT: begin
          if (out_free) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= par_word;
            out_wpar_q   <= (^par_word) ^ mode_q;
            out_is_par_q <= 1'b1;
            out_trunc_q  <= trunc_q;
            acc_q        <= '0;
            cnt_q        <= '0;
            state_q      <= PASS;
          end
        end
        default: state_q <= PASS;
      endcase
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_wpar      = out_wpar_q;
  assign bus.out_is_parity = out_is_par_q;
  assign bus.out_trunc     = out_trunc_q;
endmodule

// File: tb/tb_parity_frame_gen.sv
// Bench for parity_frame_gen: directed frames plus randomized traffic with
// backpressure, checked against a scoreboard fed by an ideal frame model.
`timescale 1ns/1ps
module tb_parity_frame_gen;
  localparam int W   = 3;
  localparam int MAX = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         wpar;
    logic         is_par;
    logic         trunc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic odd_sel;

  parity_frame_gen_if #(.WIDTH(W)) bus ();

  parity_frame_gen #(.WIDTH(W), .MAX_LEN(MAX)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .odd_sel (odd_sel),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  exp_t         sb[$];
  logic [W-1:0] par_log[$];
  int unsigned  bp = 0;        // 0: always ready, 1: random, 2: never ready
  bit           pend = 1'b0;   // model: DUT should be in the insert state

  // ideal model state
  int unsigned  m_cnt  = 0;
  logic [W-1:0] m_acc  = '0;
  logic         m_mode = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_accept(input logic [W-1:0] d, input logic last, input logic odd);
    exp_t e;
    logic [W-1:0] pw;
    if (m_cnt == 0) begin
      m_mode = odd;
      m_acc  = '0;
    end
    m_acc = m_acc ^ d;
    m_cnt++;
    e.data = d; e.wpar = (^d) ^ m_mode; e.is_par = 1'b0; e.trunc = 1'b0;
    sb.push_back(e);
    if (last || m_cnt == MAX) begin
      pw = m_acc ^ {W{m_mode}};
      e.data = pw; e.wpar = (^pw) ^ m_mode; e.is_par = 1'b1; e.trunc = !last;
      sb.push_back(e);
      m_cnt = 0;
      m_acc = '0;
      pend  = 1'b1;
    end
  endfunction

  // Sink backpressure, updated on the falling edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus.out_ready = (bp == 0) ? 1'b1 : (bp == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: samples 2ns after the falling edge, well away from the rising edge.
  initial begin : monitor
    logic [6:0] cur, held;
    bit   stall_q;
    exp_t e;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        sb.delete();
        par_log.delete();
        stall_q = 1'b0;
        pend    = 1'b0;
        m_cnt   = 0;
        m_acc   = '0;
        m_mode  = 1'b1;
      end else begin
        cur = {bus.out_valid, bus.out_data, bus.out_wpar, bus.out_is_parity, bus.out_trunc};
        if (stall_q) check("stall_hold", 32'(cur), 32'(held));
        stall_q = bus.out_valid && !bus.out_ready;
        held    = cur;
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 32'(cur), 32'd0);
          end else begin
            e = sb.pop_front();
            check(e.is_par ? "parity_word" : "data_word",
                  32'({bus.out_data, bus.out_wpar, bus.out_is_parity, bus.out_trunc}), 32'(e));
            if (bus.out_is_parity) par_log.push_back(bus.out_data);
          end
        end
        if (pend) begin
          check("in_ready_insert", 32'(bus.in_ready), 32'd0);
          if (!bus.out_valid || bus.out_ready) pend = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) model_accept(bus.in_data, bus.in_last, odd_sel);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic last, input logic odd);
    int unsigned t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    odd_sel      = odd;
    #1;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 200) check("send_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int unsigned t = 0;
    while ((sb.size() != 0 || pend) && t < 500) begin
      @(negedge clk);
      #3;
      t++;
    end
    if (t >= 500) check("drain_timeout", 32'(t), 32'd0);
  endtask

  task automatic expect_par(input string tag, input logic [W-1:0] exp);
    if (par_log.size() == 0) check({tag, "_missing"}, 32'd1, 32'd0);
    else check(tag, 32'(par_log.pop_front()), 32'(exp));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin : stim
    int unsigned len;
    rst_n        = 1'b0;
    odd_sel      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_fields", 32'({bus.out_data, bus.out_wpar, bus.out_is_parity, bus.out_trunc}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // odd frame {101, 011}
    send(3'b101, 1'b0, 1'b1);
    send(3'b011, 1'b1, 1'b1);
    drain();
    expect_par("odd_frame_par", 3'b001);

    // even frame, odd_sel flipped after the first word
    send(3'b101, 1'b0, 1'b0);
    send(3'b011, 1'b1, 1'b1);
    drain();
    expect_par("even_frame_par", 3'b110);

    // truncation at MAX_LEN=4, then remainder as a new frame
    for (int i = 1; i <= 6; i++) send(W'(i), (i == 6), 1'b1);
    drain();
    expect_par("trunc_frame_par", 3'b011);
    expect_par("tail_frame_par", 3'b100);

    // single-word frame
    send(3'b111, 1'b1, 1'b1);
    drain();
    expect_par("single_frame_par", 3'b000);

    // randomized frames with 50% backpressure
    bp = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < int'(len); i++) begin
        send(W'($urandom_range(0, 7)), (i == int'(len) - 1), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end
    drain();
    bp = 0;
    par_log.delete();
    repeat (2) @(negedge clk);

    // asynchronous reset mid-frame with a word stuck at the output
    bp = 2;
    @(negedge clk);
    send(3'b110, 1'b0, 1'b1);
    @(negedge clk);
    #3;
    check("pre_rst_stuck", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_fields", 32'({bus.out_data, bus.out_wpar, bus.out_is_parity, bus.out_trunc}), 32'd0);
    repeat (2) @(negedge clk);
    bp    = 0;
    rst_n = 1'b1;
    @(negedge clk);
    send(3'b010, 1'b0, 1'b1);
    send(3'b101, 1'b1, 1'b1);
    drain();
    expect_par("post_rst_frame_par", 3'b000);
    check("no_extra_parity", 32'(par_log.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
